// File: rtl/uart_pkg.sv
// uart_pkg: frame constants, receiver state encoding and parity helper shared by the UART transmitter and receiver
package uart_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} rx_state_t;
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/rx_sync.sv
// rx_sync: two-flop synchronizer for the serial line, resetting to the idle level 1
// ports: clk1 clock, rst async active-high reset, d async input, q synchronized output
module rx_sync (
  input  logic clk1,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk1 or posedge rst)
    if (rst) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/receiver.sv
// receiver: oversampling UART receiver, 8 data bits LSB first, even parity, one stop bit
// ports: clk1 clock, rst async active-high reset, baud_rtick oversample enable, rx serial line,
//        data_out last byte, done_r end-of-frame pulse, parity_err / frame_err status of last frame
module receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 baud_rtick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 done_r,
  output logic                 parity_err,
  output logic                 frame_err
);
  localparam int W = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [W-1:0] MID = W'(OVERSAMPLE / 2 - 1);
  localparam logic [W-1:0] LAST = W'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  rx_state_t st, st_n;
  logic rx_s, samp, par_bad;
  logic [W-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] sh;
  rx_sync u_sync (.clk1(clk1), .rst(rst), .d(rx), .q(rx_s));
  always_ff @(posedge clk1 or posedge rst)
    if (rst) st <= IDLE;
    else st <= st_n;
  // samp marks the tick on which the current state takes its sample of rx_s
  always_comb begin
    st_n = st;
    samp = 1'b0;
    if (baud_rtick)
      case (st)
        IDLE: st_n = rx_s ? IDLE : START;
        START: if (cnt == MID) begin
          samp = 1'b1;
          st_n = rx_s ? IDLE : DATA;
        end
        DATA: if (cnt == LAST) begin
          samp = 1'b1;
          st_n = (idx == LAST_BIT) ? PARITY : DATA;
        end
        PARITY: if (cnt == LAST) begin
          samp = 1'b1;
          st_n = STOP;
        end
        STOP: if (cnt == LAST) begin
          samp = 1'b1;
          st_n = rx_s ? IDLE : BRK_WAIT;
        end
        BRK_WAIT: st_n = rx_s ? IDLE : BRK_WAIT;
        default: st_n = IDLE;
      endcase
  end
  always_ff @(posedge clk1 or posedge rst)
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      par_bad <= 1'b0;
      data_out <= '0;
      done_r <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done_r <= samp && st == STOP;
      if (baud_rtick) cnt <= (samp || st == IDLE) ? '0 : cnt + 1'b1;
      if (samp && st == DATA) begin
        sh[idx] <= rx_s;
        idx <= idx + 1'b1;
      end
      if (samp && st == PARITY) par_bad <= rx_s != even_parity(sh);
      if (samp && st == STOP) begin
        data_out <= sh;
        parity_err <= par_bad;
        frame_err <= !rx_s;
      end
    end
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: randomized and directed frame stimulus against a frame-level model of the receiver
module tb_receiver;
  localparam int OS = 16;
  logic clk1 = 1'b0, rst = 1'b1, baud_rtick = 1'b0, rx = 1'b1;
  logic [7:0] data_out;
  logic done_r, parity_err, frame_err;
  int n_checks = 0, n_fail = 0, div = 0;
  logic [9:0] obs[$];
  receiver #(.OVERSAMPLE(OS)) dut (
    .clk1(clk1), .rst(rst), .baud_rtick(baud_rtick), .rx(rx),
    .data_out(data_out), .done_r(done_r), .parity_err(parity_err), .frame_err(frame_err)
  );
  always #5 clk1 = ~clk1;
  always @(posedge clk1) begin
    div <= (div == 3) ? 0 : div + 1;
    baud_rtick <= (div == 3);
  end
  always @(negedge clk1) if (done_r) obs.push_back({data_out, parity_err, frame_err});
  function automatic logic [9:0] model(input logic [7:0] d, input bit bad_par, input bit stop);
    return {d, bad_par, !stop};
  endfunction
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk1);
      while (!baud_rtick) @(posedge clk1);
    end
  endtask
  task automatic drive(input logic b, input int n);
    #1 rx = b;
    wait_ticks(n);
  endtask
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop);
    drive(1'b0, OS);
    for (int i = 0; i < 8; i++) drive(d[i], OS);
    drive((^d) ^ bad_par, OS);
    drive(stop, OS);
  endtask
  task automatic test_reset;
    #2;
    n_checks++;
    if ({data_out, done_r, parity_err, frame_err} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h/%b/%b/%b required 00/0/0/0", data_out, done_r, parity_err, frame_err);
    end
    repeat (3) @(posedge clk1);
    #1 rst = 1'b0;
    drive(1'b1, 4);
  endtask
  task automatic test_good;
    int base = obs.size();
    logic [9:0] e = model(8'hA5, 0, 1);
    send_frame(8'hA5, 0, 1);
    drive(1'b1, 4);
    n_checks++;
    if (obs.size() != base + 1) begin
      n_fail++;
      $display("FAIL good_count: got %0d done pulses required 1", obs.size() - base);
    end else begin
      n_checks++;
      if (obs[base] !== e) begin
        n_fail++;
        $display("FAIL good_A5: got %h required %h", obs[base], e);
      end
    end
  endtask
  task automatic test_parity;
    int base = obs.size();
    logic [9:0] e = model(8'h07, 1, 1);
    send_frame(8'h07, 1, 1);
    drive(1'b1, 4);
    n_checks++;
    if (obs.size() != base + 1 || obs[base] !== e) begin
      n_fail++;
      $display("FAIL parity_07: got %0d pulses last %h required 1 pulse %h", obs.size() - base, data_out, e);
    end
  endtask
  task automatic test_glitch;
    int base = obs.size();
    logic [9:0] e = model(8'h3C, 0, 1);
    drive(1'b0, 4);
    drive(1'b1, 24);
    n_checks++;
    if (obs.size() != base) begin
      n_fail++;
      $display("FAIL glitch_no_done: got %0d done pulses required 0", obs.size() - base);
    end
    send_frame(8'h3C, 0, 1);
    drive(1'b1, 4);
    n_checks++;
    if (obs.size() != base + 1 || obs[base] !== e) begin
      n_fail++;
      $display("FAIL glitch_then_3C: got %0d pulses required 1 pulse %h", obs.size() - base, e);
    end
  endtask
  task automatic test_break;
    int base = obs.size();
    logic [9:0] e0 = model(8'h55, 0, 0), e1 = model(8'h81, 0, 1);
    send_frame(8'h55, 0, 0);
    drive(1'b0, 40);
    n_checks++;
    if (obs.size() != base + 1 || obs[base] !== e0) begin
      n_fail++;
      $display("FAIL break_55: got %0d pulses required 1 pulse %h", obs.size() - base, e0);
    end
    drive(1'b1, 4);
    send_frame(8'h81, 0, 1);
    drive(1'b1, 4);
    n_checks++;
    if (obs.size() != base + 2 || obs[obs.size() - 1] !== e1) begin
      n_fail++;
      $display("FAIL break_then_81: got %0d pulses required 2, last required %h", obs.size() - base, e1);
    end
  endtask
  task automatic test_reset_mid;
    int base = obs.size();
    logic [7:0] d = 8'hF0;
    logic [9:0] e0 = model(8'h99, 1, 0), e1 = model(8'h0F, 0, 1);
    send_frame(8'h99, 1, 0);
    drive(1'b1, 8);
    n_checks++;
    if (obs.size() != base + 1 || obs[base] !== e0) begin
      n_fail++;
      $display("FAIL pre_reset_99: got %0d pulses required 1 pulse %h", obs.size() - base, e0);
    end
    base = obs.size();
    drive(1'b0, OS);
    for (int i = 0; i < 4; i++) drive(d[i], OS);
    drive(d[4], OS / 2);
    #3 rst = 1'b1;
    rx = 1'b1;
    #1;
    n_checks++;
    if ({data_out, done_r, parity_err, frame_err} !== 11'h0) begin
      n_fail++;
      $display("FAIL midframe_reset: got %h/%b/%b/%b required 00/0/0/0", data_out, done_r, parity_err, frame_err);
    end
    repeat (3) @(posedge clk1);
    #1 rst = 1'b0;
    drive(1'b1, 8);
    n_checks++;
    if (obs.size() != base) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d done pulses required 0", obs.size() - base);
    end
    send_frame(8'h0F, 0, 1);
    drive(1'b1, 4);
    n_checks++;
    if (obs.size() != base + 1 || obs[obs.size() - 1] !== e1) begin
      n_fail++;
      $display("FAIL after_reset_0F: got %0d pulses required 1 pulse %h", obs.size() - base, e1);
    end
  endtask
  task automatic test_back_to_back;
    int base = obs.size();
    logic [7:0] d[3] = '{8'h12, 8'h34, 8'h56};
    for (int i = 0; i < 3; i++) send_frame(d[i], 0, 1);
    drive(1'b1, 4);
    n_checks++;
    if (obs.size() != base + 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d done pulses required 3", obs.size() - base);
    end else
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs[base + i] !== model(d[i], 0, 1)) begin
          n_fail++;
          $display("FAIL b2b_frame%0d: got %h required %h", i, obs[base + i], model(d[i], 0, 1));
        end
      end
  endtask
  task automatic test_random;
    int base = obs.size();
    logic [9:0] exp_q[$];
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d = 8'($urandom);
      bit bad = ($urandom_range(3) == 0);
      int gap = $urandom_range(3) == 0 ? 0 : $urandom_range(20, 1);
      send_frame(d, bad, 1);
      exp_q.push_back(model(d, bad, 1));
      if (gap != 0) drive(1'b1, gap);
    end
    drive(1'b1, 4);
    n_checks++;
    if (obs.size() != base + exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d done pulses required %0d", obs.size() - base, exp_q.size());
    end else
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs[base + i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random_frame%0d: got %h required %h", i, obs[base + i], exp_q[i]);
        end
      end
  endtask
  initial begin
    test_reset;
    test_good;
    test_parity;
    test_glitch;
    test_break;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning baud_rtick pulses per bit period (even, >=8).
REQ-002 SHALL have port clk1  input  1  the single system clock; all flops are on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port baud_rtick  input  1  one-clk1-cycle enable at OVERSAMPLE x baud rate.
REQ-005 SHALL have port rx  input  1  serial line, asynchronous to clk1, idle high.
REQ-006 SHALL have port data_out  output  8  last received byte.
REQ-007 SHALL have port done_r  output  1  one-clk1-cycle pulse at the end of each frame.
REQ-008 SHALL have port parity_err  output  1  parity status of the last frame.
REQ-009 SHALL have port frame_err  output  1  stop-bit status of the last frame.

Function
REQ-010 SHALL accept frames of 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (XOR of the data bits), and 1 stop bit (1), matching the team's transmitter.
REQ-011 SHALL pass rx through a 2-flop synchronizer before any use; the synchronizer flops reset to 1.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP, and BRK_WAIT.
REQ-013 In IDLE, SHALL move to START and clear the tick counter on a synchronized rx of 0 seen on a baud_rtick.
REQ-014 In START, SHALL resample rx at tick OVERSAMPLE/2-1; if rx is 1, it SHALL return to IDLE (glitch rejection) with no done_r; if rx is 0, it SHALL move to DATA with the counter reset (the mid-bit point).
REQ-015 In DATA, SHALL sample every OVERSAMPLE ticks and shift the bit into position bit_idx (0..7); after bit 7 it SHALL move to PARITY.
REQ-016 In PARITY, SHALL sample after OVERSAMPLE ticks, compare the sample against the XOR of the 8 data bits, then move to STOP.
REQ-017 In STOP, SHALL sample after OVERSAMPLE ticks, then in the same sample cycle load data_out, parity_err, and frame_err (frame_err = !stop_sample).
REQ-018 SHALL assert done_r in the clk1 cycle after the stop-sample tick, for exactly one cycle, whether or not any error is set.
REQ-019 After STOP, SHALL go to IDLE if stop_sample is 1, otherwise to BRK_WAIT.
REQ-020 BRK_WAIT SHALL hold until synchronized rx is 1, then go to IDLE.
REQ-021 data_out, parity_err, and frame_err SHALL hold their values until the next done_r.
REQ-022 SHALL advance the tick counter only on baud_rtick; clk1 cycles without a tick SHALL change no state.
REQ-023 SHALL make the tick counter $clog2(OVERSAMPLE) bits wide and let it wrap to 0 at each sample point.
REQ-024 SHALL accept a start edge one tick after leaving STOP, so back-to-back frames receive with no idle gap.

Reset
REQ-025 On rst=1, SHALL immediately force state to IDLE, counters to 0, the shift register to 0, data_out to 8'h00, and done_r, parity_err, and frame_err to 0.
REQ-026 A reset asserted mid-frame SHALL discard the partial frame with no done_r; after release, reception SHALL resume at the next start edge.

Structure
REQ-027 SHALL take the state encoding, frame constants (DATA_BITS=8, even parity), and the OVERSAMPLE default from shared package uart_pkg, which the transmitter also uses.
REQ-028 SHALL instantiate sub-module rx_sync (2-flop synchronizer, reset value 1) for rx.

Verification
REQ-029 Frame 0xA5 with parity 0 and stop 1 -> one done_r pulse, data_out=8'hA5, parity_err=0, frame_err=0.
REQ-030 Frame 0x07 with wrong parity bit 0 -> done_r, data_out=8'h07, parity_err=1, frame_err=0.
REQ-031 rx low for 4 ticks, then high -> no done_r; state returns to IDLE; the following frame 0x3C receives correctly.
REQ-032 Frame 0x55 with stop bit 0, then rx held low for 40 ticks -> done_r once, frame_err=1, FSM in BRK_WAIT until rx rises, then 0x81 receives with frame_err=0.
REQ-033 rst asserted at data bit 4 of 0xF0 -> outputs 0 immediately, no done_r; the next frame 0x0F gives data_out=8'h0F.
REQ-034 Back-to-back frames 0x12, 0x34, 0x56 with no idle gap -> three done_r pulses with matching data_out and no errors.
